apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB responder: the peripheral end of the bridge's APB initiator, answering Pselx/Penable/Pwrite/Paddr/Pwdata transfers with Prdata.
- Contains a small word-addressed register bank, a programmable wait-state generator (Pready) and error signalling (Pslverr).
- One instance hangs off each Pselx bit; the bridge uses it as its default test target and the bench uses it as its APB scoreboard endpoint.
- With WAIT_CYCLES=0 it is zero-wait and APB2-timing compatible.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of register 0.
- NUM_REGS, 8, number of 32-bit registers; power of two, 2..256.
- WAIT_CYCLES, 0, wait states inserted in every access phase; 0..15.
- ID_VALUE, 32'hA0B0_0001, constant returned by read-only register 0.

Ports:
- Hclk  in  1  single clock for the block.
- Hresetin  in  1  synchronous reset, active-high.
- Psel  in  1  this slave's select (one bit of Pselx).
- Penable  in  1  access-phase indicator.
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  32  byte address.
- Pwdata  in  32  write data.
- Prdata  out  32  read data; valid when Pready=1 on a read.
- Pready  out  1  transfer completes on this cycle's edge.
- Pslverr  out  1  error response; valid only while Pready=1.
- err_count  out  8  saturating count of errored transfers.

Behaviour:
Reset:
- Hresetin=1 at a clock edge: state ST_IDLE, all registers 0, Prdata=0, Pready=0, Pslverr=0, err_count=0.
- Reset overrides any in-flight transfer; the transfer is dropped with no commit.

FSM (registered state; Pready = (state==ST_READY)):
- ST_IDLE:
  - Setup (Psel=1, Penable=0): latch Paddr, Pwrite, Pwdata; decode. Go to ST_READY if WAIT_CYCLES=0, else ST_WAIT with cnt=WAIT_CYCLES.
  - Penable=1 without a preceding setup: ignored, stay ST_IDLE.
- ST_WAIT:
  - Psel=1, Penable=1: cnt decrements; at cnt==1 go to ST_READY.
  - Psel=0: abort, go to ST_IDLE, no commit, no error counted.
- ST_READY:
  - Completing edge (Psel=1, Penable=1): commit a valid write, update err_count if errored, go to ST_IDLE.
  - Psel=0: go to ST_IDLE, no commit.

Timing:
- Access phase lasts WAIT_CYCLES+1 cycles. Back-to-back setups are accepted in the cycle after completion.

Decode (on the latched address):
- Error if Paddr[1:0]!=0, or Paddr<BASE_ADDR, or index=(Paddr-BASE_ADDR)>>2 >= NUM_REGS, or a write to index 0.
- Address arithmetic is 32-bit unsigned; the subtraction must not wrap into range.

Read data:
- Prdata is loaded on entry to ST_READY: ID_VALUE for index 0, reg[index] otherwise, 0 on error.
- Prdata holds its value outside ST_READY.

Pslverr and writes:
- Pslverr is registered with Pready on entry to ST_READY and cleared on leaving it.
- Errored writes never modify any register.
- Writes take effect at the completing edge; a read setup in the next cycle sees the new value.

err_count:
- +1 per completed errored transfer; saturates at 8'hFF.

Decomposition:
- Package apb_slave_pkg: state encoding (ST_IDLE, ST_WAIT, ST_READY, 2 bits), default ID_VALUE, the error-cause encoding used by decode.
- Sub-module apb_regbank: NUM_REGS x 32 storage, one write port and one combinational read port, synchronous reset.
- FSM, wait counter, decode and err_count stay in the top.

Test Plan:
- WAIT_CYCLES=0, write 32'hDEAD_BEEF to BASE+4, then read BASE+4 -> each Pready=1 on the first access cycle; Prdata=32'hDEAD_BEEF, Pslverr=0.
- WAIT_CYCLES=3, read BASE+0 -> Pready low for 3 access cycles, high on the 4th; Prdata=32'hA0B0_0001.
- Write BASE+0, write BASE+2 (misaligned), read BASE+32 (out of range) -> each Pslverr=1 with Pready. Read returns Prdata=0; register 0 unchanged; err_count=3.
- WAIT_CYCLES=2, deassert Psel in the first wait cycle of a write to BASE+8 -> state ST_IDLE, register 2 stays 0, err_count unchanged.
- Hresetin=1 mid-WAIT after registers were written -> next cycle all outputs 0 and a read of BASE+4 returns 0.
- 300 consecutive errored transfers -> err_count stops at 8'hFF.

Source files
------------

// File: rtl/apb_slave_pkg.sv
// apb_slave_pkg: shared FSM states, decode error causes and address helpers for the APB register slave.
package apb_slave_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_ALIGN, ERR_RANGE, ERR_RO} err_t;
  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA0B0_0001;
  // Below-base is checked before the offset so the subtraction can never wrap into range.
  function automatic err_t decode(input logic [31:0] addr, input logic [31:0] base,
                                  input int unsigned num, input logic wr);
    logic [31:0] off;
    off = addr - base;
    if (addr[1:0] != 2'b00) return ERR_ALIGN;
    if (addr < base || (off >> 2) >= num) return ERR_RANGE;
    return (wr && off[31:2] == 30'd0) ? ERR_RO : ERR_NONE;
  endfunction
  function automatic logic [7:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return off[9:2];
  endfunction
endpackage

// File: rtl/apb_regbank.sv
// apb_regbank: NUM_REGS x 32 register storage with one write port and one combinational read port.
module apb_regbank #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [N];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < N; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB responder with a word register bank, programmable wait states and error reporting.
module apb_slave_regfile import apb_slave_pkg::*; #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
  input  logic        Hclk,
  input  logic        Hresetin,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr,
  output logic [7:0]  err_count
);
  localparam int IW = $clog2(NUM_REGS);
  state_t state, state_n;
  logic [3:0] cnt;
  logic [31:0] addr_q, wdata_q, rdata;
  logic write_q;
  logic setup, access, write_d, we;
  logic [31:0] addr_d;
  logic [IW-1:0] idx_d;
  err_t err_d;
  // In idle the live bus is decoded so a zero-wait setup can load Prdata on the same edge.
  assign setup   = Psel & ~Penable;
  assign access  = Psel & Penable;
  assign addr_d  = (state == ST_IDLE) ? Paddr : addr_q;
  assign write_d = (state == ST_IDLE) ? Pwrite : write_q;
  assign err_d   = decode(addr_d, BASE_ADDR, NUM_REGS, write_d);
  assign idx_d   = IW'(word_index(addr_d, BASE_ADDR));
  assign Pready  = (state == ST_READY);
  assign we      = Pready & access & write_q & ~Pslverr;
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (setup) state_n = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
      ST_WAIT:  state_n = !Psel ? ST_IDLE : (access && cnt == 4'd1) ? ST_READY : ST_WAIT;
      ST_READY: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge Hclk)
    if (Hresetin) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      Prdata    <= '0;
      Pslverr   <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && setup) begin
        addr_q  <= Paddr;
        write_q <= Pwrite;
        wdata_q <= Pwdata;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == ST_WAIT && access) cnt <= cnt - 4'd1;
      if (state_n == ST_READY && state != ST_READY) begin
        Prdata  <= (err_d != ERR_NONE) ? '0 : (idx_d == '0) ? ID_VALUE : rdata;
        Pslverr <= (err_d != ERR_NONE);
      end else if (state_n != ST_READY) Pslverr <= 1'b0;
      if (Pready && access && Pslverr && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  apb_regbank #(.N(NUM_REGS), .IW(IW)) u_bank (
    .clk(Hclk), .rst(Hresetin), .we(we), .waddr(idx_d), .wdata(wdata_q), .raddr(idx_d), .rdata(rdata)
  );
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: three slaves (0/2/3 wait states) driven by table vectors and corner sequences, checked via a scoreboard.
module tb_apb_slave_regfile;
  localparam logic [31:0] B = 32'h0000_1000;
  typedef struct {bit wr; logic [31:0] addr; logic [31:0] data; logic [31:0] rdata; bit err;} vec_t;
  typedef struct {logic [31:0] rdata; bit err; bit chk;} exp_t;
  logic clk = 0;
  logic rst [3];
  logic psel [3];
  logic penable = 0, pwrite = 0;
  logic [31:0] paddr = 0, pwdata = 0;
  logic [31:0] prdata [3];
  logic pready [3], pslverr [3];
  logic [7:0] errc [3];
  int wt [3] = '{0, 2, 3};
  int n_cmp = 0, n_bad = 0;
  exp_t sb [$];
  vec_t tbl [12];
  always #5 clk = ~clk;

  apb_slave_regfile #(.BASE_ADDR(B), .WAIT_CYCLES(0)) u0 (.Hclk(clk), .Hresetin(rst[0]), .Psel(psel[0]),
    .Penable(penable), .Pwrite(pwrite), .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[0]),
    .Pready(pready[0]), .Pslverr(pslverr[0]), .err_count(errc[0]));
  apb_slave_regfile #(.BASE_ADDR(B), .WAIT_CYCLES(2)) u1 (.Hclk(clk), .Hresetin(rst[1]), .Psel(psel[1]),
    .Penable(penable), .Pwrite(pwrite), .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[1]),
    .Pready(pready[1]), .Pslverr(pslverr[1]), .err_count(errc[1]));
  apb_slave_regfile #(.BASE_ADDR(B), .WAIT_CYCLES(3)) u2 (.Hclk(clk), .Hresetin(rst[2]), .Psel(psel[2]),
    .Penable(penable), .Pwrite(pwrite), .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[2]),
    .Pready(pready[2]), .Pslverr(pslverr[2]), .err_count(errc[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input bit ee, input bit chk);
    int w = 0;
    exp_t e;
    sb.push_back('{er, ee, chk});
    psel[k] = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    tick();
    penable = 1;
    @(negedge clk);
    while (!pready[k] && w < 20) begin
      @(negedge clk);
      w++;
    end
    e = sb.pop_front();
    check($sformatf("pready[%0d]", k), {31'd0, pready[k]}, 32'd1);
    check($sformatf("waits[%0d]", k), w, wt[k]);
    if (e.chk) check($sformatf("prdata[%0d] @%h", k, a), prdata[k], e.rdata);
    check($sformatf("pslverr[%0d] @%h", k, a), {31'd0, pslverr[k]}, {31'd0, e.err});
    tick();
    psel[k] = 0; penable = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin rst[i] = 1; psel[i] = 0; end
    tbl[0]  = '{1, B + 4,  32'hDEAD_BEEF, 32'h0,          0};
    tbl[1]  = '{0, B + 4,  32'h0,         32'hDEAD_BEEF,  0};
    tbl[2]  = '{0, B + 0,  32'h0,         32'hA0B0_0001,  0};
    tbl[3]  = '{1, B + 0,  32'h1111_1111, 32'h0,          1};
    tbl[4]  = '{1, B + 2,  32'h2222_2222, 32'h0,          1};
    tbl[5]  = '{0, B + 32, 32'h0,         32'h0,          1};
    tbl[6]  = '{0, B + 0,  32'h0,         32'hA0B0_0001,  0};
    tbl[7]  = '{1, B + 28, 32'h1234_5678, 32'h0,          0};
    tbl[8]  = '{0, B + 28, 32'h0,         32'h1234_5678,  0};
    tbl[9]  = '{0, B - 4,  32'h0,         32'h0,          1};
    tbl[10] = '{0, 32'hFFFF_FFFC, 32'h0,  32'h0,          1};
    tbl[11] = '{1, B + 5,  32'h5555_5555, 32'h0,          1};
    tick(); tick();
    for (int i = 0; i < 3; i++) rst[i] = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst prdata[%0d]", i), prdata[i], 32'h0);
      check($sformatf("rst pready[%0d]", i), {31'd0, pready[i]}, 32'h0);
      check($sformatf("rst errc[%0d]", i), {24'd0, errc[i]}, 32'h0);
    end
    tick();
    for (int i = 0; i < 12; i++)
      xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].rdata, tbl[i].err, !tbl[i].wr || tbl[i].err);
    xfer(0, 0, B + 4, 0, 32'hDEAD_BEEF, 0, 1);
    @(negedge clk);
    check("errc[0] after table", {24'd0, errc[0]}, 32'd6);
    tick();
    xfer(2, 0, B + 0, 0, 32'hA0B0_0001, 0, 1);
    xfer(1, 1, B + 12, 32'hCAFE_0003, 0, 0, 0);
    xfer(1, 0, B + 12, 0, 32'hCAFE_0003, 0, 1);
    psel[1] = 1; penable = 0; pwrite = 1; paddr = B + 8; pwdata = 32'h7777_7777;
    tick();
    psel[1] = 0;
    tick();
    check("abort pready[1]", {31'd0, pready[1]}, 32'h0);
    check("abort errc[1]", {24'd0, errc[1]}, 32'h0);
    xfer(1, 0, B + 8, 0, 32'h0, 0, 1);
    xfer(1, 0, B + 2, 0, 32'h0, 1, 1);
    xfer(1, 1, B + 4, 32'h0000_0011, 0, 0, 0);
    xfer(1, 0, B + 4, 0, 32'h0000_0011, 0, 1);
    psel[1] = 1; penable = 0; pwrite = 0; paddr = B + 4;
    tick();
    penable = 1;
    tick();
    rst[1] = 1; psel[1] = 0; penable = 0;
    tick();
    rst[1] = 0;
    @(negedge clk);
    check("midrst prdata[1]", prdata[1], 32'h0);
    check("midrst pready[1]", {31'd0, pready[1]}, 32'h0);
    check("midrst pslverr[1]", {31'd0, pslverr[1]}, 32'h0);
    check("midrst errc[1]", {24'd0, errc[1]}, 32'h0);
    tick();
    xfer(1, 0, B + 4, 0, 32'h0, 0, 1);
    for (int i = 0; i < 248; i++) xfer(0, 0, B + 1, 0, 32'h0, 1, 1);
    @(negedge clk);
    check("errc[0] at 254", {24'd0, errc[0]}, 32'd254);
    tick();
    for (int i = 0; i < 52; i++) xfer(0, 1, B + 0, 0, 32'h0, 1, 1);
    @(negedge clk);
    check("errc[0] saturated", {24'd0, errc[0]}, 32'hFF);
    check("scoreboard empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
